jsequential_divider: RTL and testbench



---
 rtl/jsequential_divider.sv | 120 ++++++++++++
 tb/tb_jsequential_divider.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/jsequential_divider.sv
// Sequential unsigned restoring divider: 8-bit dividend / 4-bit divisor.
// One quotient bit per clock under a start/busy/done handshake.
module jsequential_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] d_q, d_d;       // dividend shifting out, quotient shifting in
  logic [3:0] v_q, v_d;       // latched divisor
  logic [3:0] r_q, r_d;       // partial remainder; its 5th bit is always zero at rest
  logic [2:0] k_q, k_d;       // iteration counter
  logic [7:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;

  logic [4:0] trial;
  logic [4:0] diff;
  logic       q_bit;
  logic [7:0] d_shift;
  logic [3:0] r_next;

  // Datapath for one restoring step; only the 5-bit compare needs the extra bit.
  always_comb begin
    trial   = {r_q, d_q[7]};
    diff    = trial - {1'b0, v_q};
    q_bit   = (trial >= {1'b0, v_q});
    r_next  = q_bit ? diff[3:0] : trial[3:0];
    d_shift = {d_q[6:0], q_bit};
  end

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    v_d     = v_q;
    r_d     = r_q;
    k_d     = k_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d = dividend;
          v_d = divisor;
          r_d = '0;
          k_d = '0;
          if (divisor == 4'd0) begin
            state_d = S_DONE;
            quot_d  = 8'hFF;
            rem_d   = 4'hF;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        d_d = d_shift;
        r_d = r_next;
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) begin
          state_d = S_DONE;
          quot_d  = d_shift;
          rem_d   = r_next;
          dbz_d   = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      v_q     <= v_d;
      r_q     <= r_d;
      k_q     <= k_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Outputs decode directly from registered state, so nothing is combinational from inputs.
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_jsequential_divider.sv
// Self-checking bench for jsequential_divider: directed cases, randomized
// operations and a full operand sweep against a plain-arithmetic model.
module tb_jsequential_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  jsequential_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference results: {quotient, remainder, div_by_zero}.
  function automatic logic [12:0] model(input logic [7:0] a, input logic [3:0] b);
    if (b == 4'd0) return {8'hFF, 4'hF, 1'b0 | 1'b1};
    return {8'(a / b), 4'(a % b), 1'b0};
  endfunction

  // Array multiplier behaviour: sum of shifted partial products.
  function automatic logic [11:0] array_mult(input logic [7:0] q, input logic [3:0] v);
    logic [11:0] acc;
    acc = '0;
    for (int j = 0; j < 4; j++)
      if (v[j]) acc = acc + ({4'b0, q} << j);
    return acc;
  endfunction

  // Issue one operation from IDLE (called at posedge+1); returns when done is seen
  // or the cycle budget runs out. lat counts edges after the accepting edge.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit disturb,
                        output int lat, output bit busy_seen);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start     = 1'b0;
    lat       = 0;
    busy_seen = busy;
    while (!done && lat < 20) begin
      if (disturb && lat == 2) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd3;
      end else begin
        start = 1'b0;
      end
      if (disturb && lat == 4) begin
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      busy_seen |= busy;
    end
    start = 1'b0;
  endtask

  task automatic do_and_check(input string tag, input logic [7:0] a, input logic [3:0] b,
                              input bit disturb);
    int          lat;
    bit          busy_seen;
    logic [12:0] exp;
    exp = model(a, b);
    run_op(a, b, disturb, lat, busy_seen);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(lat), (b == 4'd0) ? 32'd0 : 32'd8);
    check({tag, "_busy_seen"}, 32'(busy_seen), 32'(b != 4'd0));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_result"}, 32'({quotient, remainder, div_by_zero}), 32'(exp));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_held"}, 32'({quotient, remainder, div_by_zero}), 32'(exp));
  endtask

  initial begin
    int  lat;
    bit  busy_seen;
    int  extra_done;
    bit  unstable;
    int  gap;
    logic [12:0] snap;
    logic [7:0]  ra;
    logic [3:0]  rb;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #23;
    check("reset_outputs", 32'({busy, done, quotient, remainder, div_by_zero}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of an operation.
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_run_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({busy, done, quotient, remainder, div_by_zero}), 32'd0);
    extra_done = 0;
    repeat (10) begin @(posedge clk); #1; if (done) extra_done++; end
    check("abort_no_done", 32'(extra_done), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_and_check("after_reset_200_7", 8'd200, 4'd7, 1'b0);

    // Directed cases.
    do_and_check("d_200_7", 8'd200, 4'd7, 1'b0);
    do_and_check("d_255_1", 8'd255, 4'd1, 1'b0);
    do_and_check("d_255_15", 8'd255, 4'd15, 1'b0);
    do_and_check("d_5_9", 8'd5, 4'd9, 1'b0);
    do_and_check("d_100_0", 8'd100, 4'd0, 1'b0);
    do_and_check("d_100_10", 8'd100, 4'd10, 1'b0);
    do_and_check("d_0_3", 8'd0, 4'd3, 1'b0);

    // start pulsed and operands changed while running.
    do_and_check("disturb_200_7", 8'd200, 4'd7, 1'b1);
    snap       = {quotient, remainder, div_by_zero};
    extra_done = 0;
    unstable   = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) extra_done++;
      if ({quotient, remainder, div_by_zero} !== snap) unstable = 1'b1;
    end
    check("no_second_op", 32'(extra_done), 32'd0);
    check("idle_stable", 32'(unstable), 32'd0);

    // start held high: operations accepted back to back, 10 cycles apart.
    start    = 1'b1;
    dividend = 8'd20;
    divisor  = 4'd3;
    lat = 0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    check("held_first_done", 32'(done), 32'd1);
    gap = 0;
    do begin @(posedge clk); #1; gap++; end while (!done && gap < 30);
    start = 1'b0;
    check("held_gap", 32'(gap), 32'd10);
    check("held_result", 32'({quotient, remainder, div_by_zero}), 32'(model(8'd20, 4'd3)));
    @(posedge clk); #1;

    // Randomized operations, including zero divisors, with idle gaps.
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 4'($urandom);
      do_and_check("rand", ra, rb, 1'b0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Full sweep: quotient*divisor + remainder must rebuild the dividend.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(8'(a), 4'(b), 1'b0, lat, busy_seen);
        check("sweep_done", 32'(done), 32'd1);
        check("sweep_result", 32'({quotient, remainder, div_by_zero}), 32'(model(8'(a), 4'(b))));
        check("sweep_rebuild", 32'(array_mult(quotient, 4'(b)) + 12'(remainder)), 32'(a));
        check("sweep_rem_lt", 32'(remainder < 4'(b)), 32'd1);
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
